ldpc_iter_ctrl: RTL and testbench
=================================

Name: ldpc_iter_ctrl

Overview:
- Iteration controller and early-termination stage for the QC-LDPC decoder. Sits between the decoder core and the syndrome checker.
- Each iteration it does three things:
  - triggers one decoder iteration;
  - latches the resulting hard-decision vector and drives it to the syndrome checker;
  - samples the checker result to decide whether to stop: converged, or iteration budget exhausted.
- The final hard decision is delivered downstream on a valid/ready handshake, together with the iteration count and a converged flag.

Parameters:
- R, 4, number of block rows of the hard-decision vector (matches checker R).
- D, 8, circulant size in bits (matches checker D).
- MAX_ITER, 16, maximum decoder iterations per frame; legal range 1..2^IT_W-1.
- IT_W, 5, width of the iteration counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin decoding a new frame; accepted only in IDLE.
- iter_go  out  1  one-cycle pulse: decoder core runs one iteration.
- hd_valid  in  1  decoder core hard decision valid; one-cycle pulse.
- hd  in  R*D  hard-decision vector from the core, block row j at bits [j*D +: D].
- chk_dec  out  R*D  registered hard decision driven to the syndrome checker.
- chk_res  in  1  checker result, combinational from chk_dec; 1 = syndrome nonzero.
- out_valid  out  1  final result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  R*D  final hard decision (equals chk_dec while out_valid).
- out_iters  out  IT_W  iterations used for this frame, 1..MAX_ITER.
- out_conv  out  1  1 = syndrome zero at termination.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - iter_go=0, chk_dec=0, out_valid=0, out_iters=0, out_conv=0, busy=0.
  - State = IDLE; iteration counter it_cnt=0.
- States and transitions:
  - IDLE:
    - start=1 → iter_go=1 on the next cycle; it_cnt←0; go to WAIT.
    - start=0 → no action.
  - WAIT (waiting for the core):
    - hd_valid=1 → chk_dec←hd; it_cnt←it_cnt+1; go to CHECK.
    - iter_go stays low in WAIT after its single pulse.
  - CHECK (one cycle; chk_res is stable from the registered chk_dec):
    - chk_res=0 → out_conv←1; go to OUT.
    - chk_res=1 and it_cnt==MAX_ITER → out_conv←0; go to OUT.
    - otherwise → iter_go=1 on the next cycle; go to WAIT.
  - OUT:
    - out_valid=1; out_iters=it_cnt.
    - out_data, out_iters and out_conv are held stable until the handshake completes.
    - out_valid & out_ready → go to IDLE; out_valid deasserts on the next cycle.
- iter_go is registered: a single one-cycle pulse per iteration, asserted in the first cycle of WAIT.
- Latency, with hd_valid returned k cycles after iter_go:
  - each iteration costs k+2 cycles (WAIT k+1, CHECK 1);
  - the first out_valid comes 1 cycle after the final CHECK.
- Boundary conditions:
  - hd_valid arriving in the same cycle as iter_go (k=0) is legal and is captured.
  - start while busy=1 is ignored; no queuing.
  - hd_valid outside WAIT is ignored; chk_dec is unchanged.
  - out_ready while out_valid=0 has no effect.
  - start asserted in the same cycle OUT→IDLE completes is ignored, because the state is still OUT in that cycle.
  - MAX_ITER=1: terminates after the first CHECK regardless of chk_res.
  - it_cnt never exceeds MAX_ITER; no wrap-around.
  - chk_dec keeps its value after OUT until the next hd capture.
  - rst_n asserted mid-frame: immediate return to the reset values; the in-flight frame is discarded; the core sees no further iter_go.
- Arithmetic: it_cnt is unsigned IT_W bits; the comparison with MAX_ITER is at IT_W width.

Decomposition:
- Shared package ldpc_pkg holds:
  - state enum: IDLE, WAIT, CHECK, OUT;
  - default R, D, MAX_ITER, IT_W;
  - the shift-value width and the all-ones "zero block" encoding, for consistency with the checker.
- Single flat module. No sub-module needed: the syndrome checker stays external and is connected through chk_dec/chk_res.
- The bench instantiates the checker alongside this block.

Test Plan:
- Immediate convergence: start; core returns hd=32'h0 after k=3; chk_res=0 → out_valid 1 cycle after CHECK; out_iters=1; out_conv=1; out_data=32'h0.
- Convergence at iteration 5: chk_res=1 for the first 4 CHECKs, 0 on the 5th → exactly 5 iter_go pulses; out_iters=5; out_conv=1; out_data equals the 5th hd (e.g. 32'hA5A5_0F0F).
- Budget exhausted: chk_res stuck at 1, MAX_ITER=16 → 16 iter_go pulses; out_iters=16; out_conv=0; no 17th pulse.
- Backpressure and ignored inputs: hold out_ready=0 for 10 cycles; pulse start and hd_valid during OUT → outputs stable, state stays OUT; out_ready=1 → IDLE next cycle.
- Zero-latency core, k=0, with MAX_ITER=1 → hd captured in the iter_go cycle; terminates after one CHECK; out_iters=1.
- Reset mid-frame: assert rst_n=0 in WAIT of iteration 3 → all outputs at reset values asynchronously; after release, start begins a fresh frame with out_iters counting from 1.

Source files
------------

// File: rtl/ldpc_pkg.sv
// Shared definitions for the QC-LDPC decoder control path: default geometry,
// iteration-controller states and the circulant shift encoding used by the checker.
package ldpc_pkg;

    localparam int R_DEF        = 4;
    localparam int D_DEF        = 8;
    localparam int MAX_ITER_DEF = 16;
    localparam int IT_W_DEF     = 5;

    // One extra bit so the all-ones code cannot collide with a legal shift 0..D-1
    localparam int                  SHIFT_W  = $clog2(D_DEF) + 1;
    localparam logic [SHIFT_W-1:0]  ZERO_BLK = {SHIFT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/ldpc_iter_ctrl.sv
// Iteration controller with early termination: triggers decoder iterations,
// feeds each hard decision to the syndrome checker and hands off the final result.
module ldpc_iter_ctrl
    import ldpc_pkg::*;
#(
    parameter int R        = R_DEF,
    parameter int D        = D_DEF,
    parameter int MAX_ITER = MAX_ITER_DEF,
    parameter int IT_W     = IT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              iter_go,
    input  logic              hd_valid,
    input  logic [R*D-1:0]    hd,
    output logic [R*D-1:0]    chk_dec,
    input  logic              chk_res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [R*D-1:0]    out_data,
    output logic [IT_W-1:0]   out_iters,
    output logic              out_conv,
    output logic              busy
);

    localparam int              W       = R * D;
    localparam logic [IT_W-1:0] MAX_CNT = IT_W'(MAX_ITER);

    state_t            state_r,     state_s;
    logic              iter_go_r,   iter_go_s;
    logic [W-1:0]      chk_dec_r,   chk_dec_s;
    logic [IT_W-1:0]   it_cnt_r,    it_cnt_s;
    logic [IT_W-1:0]   out_iters_r, out_iters_s;
    logic              out_valid_r, out_valid_s;
    logic              out_conv_r,  out_conv_s;
    logic              busy_r;

    // Next-state and next-output decode; every register holds unless a state says otherwise
    always_comb begin
        state_s     = state_r;
        iter_go_s   = 1'b0;
        chk_dec_s   = chk_dec_r;
        it_cnt_s    = it_cnt_r;
        out_iters_s = out_iters_r;
        out_valid_s = out_valid_r;
        out_conv_s  = out_conv_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s   = WAIT;
                    iter_go_s = 1'b1;
                    it_cnt_s  = {IT_W{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (hd_valid) begin
                    chk_dec_s = hd;
                    it_cnt_s  = it_cnt_r + IT_W'(1);
                    state_s   = CHECK;
                end else begin
                    state_s = WAIT;
                end
            end
            CHECK: begin
                // chk_res is settled here because chk_dec was registered on entry
                if (!chk_res) begin
                    out_conv_s  = 1'b1;
                    out_valid_s = 1'b1;
                    out_iters_s = it_cnt_r;
                    state_s     = OUT;
                end else if (it_cnt_r >= MAX_CNT) begin
                    out_conv_s  = 1'b0;
                    out_valid_s = 1'b1;
                    out_iters_s = it_cnt_r;
                    state_s     = OUT;
                end else begin
                    iter_go_s = 1'b1;
                    state_s   = WAIT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_s = 1'b0;
                    state_s     = IDLE;
                end else begin
                    state_s = OUT;
                end
            end
            default: begin
                out_valid_s = 1'b0;
                state_s     = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            iter_go_r   <= 1'b0;
            chk_dec_r   <= {W{1'b0}};
            it_cnt_r    <= {IT_W{1'b0}};
            out_iters_r <= {IT_W{1'b0}};
            out_valid_r <= 1'b0;
            out_conv_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            iter_go_r   <= iter_go_s;
            chk_dec_r   <= chk_dec_s;
            it_cnt_r    <= it_cnt_s;
            out_iters_r <= out_iters_s;
            out_valid_r <= out_valid_s;
            out_conv_r  <= out_conv_s;
            busy_r      <= (state_s != IDLE);
        end
    end

    assign iter_go   = iter_go_r;
    assign chk_dec   = chk_dec_r;
    assign out_data  = chk_dec_r;
    assign out_iters = out_iters_r;
    assign out_valid = out_valid_r;
    assign out_conv  = out_conv_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Self-checking bench for ldpc_iter_ctrl: randomized frames against a frame-level
// reference model, plus directed backpressure, reset and MAX_ITER=1 scenarios.
module tb_ldpc_iter_ctrl;

    localparam int MAXI = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, hd_valid, chk_res, out_ready;
    logic [31:0] hd, chk_dec, out_data;
    logic        iter_go, out_valid, out_conv, busy;
    logic [4:0]  out_iters;
    logic [31:0] target;

    logic        b_start, b_hd_valid, b_chk_res, b_out_ready;
    logic [31:0] b_hd, b_chk_dec, b_out_data;
    logic        b_iter_go, b_out_valid, b_out_conv, b_busy;
    logic [4:0]  b_out_iters;

    int total = 0;
    int bad   = 0;
    int pulses;

    always #5 clk = ~clk;

    // Behavioural syndrome checker: the frame "converges" when the decision equals target
    assign chk_res   = (chk_dec != target);
    assign b_chk_res = (b_chk_dec != 32'h0000_0000);

    ldpc_iter_ctrl #(.R(4), .D(8), .MAX_ITER(MAXI), .IT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .iter_go(iter_go),
        .hd_valid(hd_valid), .hd(hd), .chk_dec(chk_dec), .chk_res(chk_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_iters(out_iters), .out_conv(out_conv), .busy(busy)
    );

    ldpc_iter_ctrl #(.R(4), .D(8), .MAX_ITER(1), .IT_W(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(b_start), .iter_go(b_iter_go),
        .hd_valid(b_hd_valid), .hd(b_hd), .chk_dec(b_chk_dec), .chk_res(b_chk_res),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_iters(b_out_iters), .out_conv(b_out_conv), .busy(b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One frame: conv_at = iteration whose hd equals target (0 = never), k drawn per iteration
    task automatic run_frame(input logic [31:0] tgt, input int conv_at,
                             input int kmin, input int kmax, input int hold);
        logic [31:0] hd_q [MAXI];
        int          exp_iters, exp_lat, lat, np, k;
        logic        exp_conv;
        logic [31:0] exp_data;
        target = tgt;
        for (int i = 0; i < MAXI; i++) begin
            hd_q[i] = $urandom();
            if (hd_q[i] == tgt) hd_q[i] = ~tgt;
            if (i == conv_at - 1) hd_q[i] = tgt;
        end
        exp_iters = MAXI;
        exp_conv  = 1'b0;
        for (int i = MAXI - 1; i >= 0; i--) begin
            if (hd_q[i] == tgt) begin
                exp_iters = i + 1;
                exp_conv  = 1'b1;
            end
        end
        exp_data = hd_q[exp_iters-1];

        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0; np = 0; exp_lat = 0;
        while (!out_valid && lat < 2000) begin
            if (iter_go) begin
                np++;
                k = $urandom_range(kmax, kmin);
                exp_lat += k + 2;
                repeat (k) begin
                    tick(); lat++;
                    if (iter_go) np++;
                end
                hd_valid = 1'b1;
                hd = hd_q[(np - 1) % MAXI];
                tick(); lat++;
                hd_valid = 1'b0;
                hd = $urandom();
            end else begin
                tick(); lat++;
            end
        end
        check("latency",    lat,       exp_lat);
        check("go_pulses",  np,        exp_iters);
        check("out_valid",  out_valid, 1);
        check("out_iters",  out_iters, exp_iters);
        check("out_conv",   out_conv,  exp_conv);
        check("out_data",   out_data,  exp_data);
        check("busy_out",   busy,      1);

        // Backpressure with start/hd_valid pokes that must be ignored in OUT
        for (int c = 0; c < hold; c++) begin
            out_ready = 1'b0;
            start     = 1'($urandom_range(1, 0));
            hd_valid  = 1'($urandom_range(1, 0));
            hd        = $urandom();
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_data",  out_data,  exp_data);
            check("hold_iters", out_iters, exp_iters);
            check("hold_conv",  out_conv,  exp_conv);
            check("hold_go",    iter_go,   0);
        end
        hd_valid  = 1'b0;
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check("done_valid", out_valid, 0);
        check("done_busy",  busy,      0);
        check("done_go",    iter_go,   0);
        check("chk_keep",   chk_dec,   exp_data);
        tick();
        check("late_start_go",   iter_go, 0);
        check("late_start_busy", busy,    0);

        // Idle stray inputs
        out_ready = 1'b1;
        hd_valid  = 1'b1;
        hd        = ~exp_data;
        tick();
        out_ready = 1'b0;
        hd_valid  = 1'b0;
        check("idle_hd_ignored", chk_dec,   exp_data);
        check("idle_valid",      out_valid, 0);
        check("idle_busy",       busy,      0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; hd_valid = 1'b0; out_ready = 1'b0;
        hd = 32'h0; target = 32'h0;
        b_start = 1'b0; b_hd_valid = 1'b0; b_out_ready = 1'b0; b_hd = 32'h0;
        tick(); tick();
        check("rst_go",    iter_go,   0);
        check("rst_dec",   chk_dec,   0);
        check("rst_valid", out_valid, 0);
        check("rst_iters", out_iters, 0);
        check("rst_conv",  out_conv,  0);
        check("rst_busy",  busy,      0);
        rst_n = 1'b1;
        tick();

        run_frame(32'h0000_0000, 1, 3, 3, 2);
        run_frame(32'hA5A5_0F0F, 5, 0, 4, 10);
        run_frame($urandom(), 0, 0, 2, 3);
        for (int f = 0; f < 4; f++) begin
            run_frame($urandom(), $urandom_range(MAXI, 0), 0, 3, $urandom_range(4, 0));
        end

        // Reset during WAIT of iteration 3
        target = 32'h1234_5678;
        start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0;
        for (int c = 0; c < 200 && pulses < 3; c++) begin
            if (iter_go) begin
                pulses++;
                if (pulses < 3) begin
                    hd = ~target; hd_valid = 1'b1;
                    tick();
                    hd_valid = 1'b0;
                end
            end else begin
                tick();
            end
        end
        check("mid_reach_iter3", pulses, 3);
        tick();
        check("mid_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_go",    iter_go,   0);
        check("arst_dec",   chk_dec,   0);
        check("arst_valid", out_valid, 0);
        check("arst_iters", out_iters, 0);
        check("arst_conv",  out_conv,  0);
        check("arst_busy",  busy,      0);
        hd_valid = 1'b1;
        tick();
        hd_valid = 1'b0;
        tick();
        check("arst_hold_go", iter_go, 0);
        check("arst_hold_dec", chk_dec, 0);
        rst_n = 1'b1;
        tick();
        run_frame(32'h0F0F_F0F0, 1, 0, 2, 1);

        // MAX_ITER=1 instance, zero-latency core, syndrome stays nonzero
        check("b_rst_iters", b_out_iters, 0);
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check("b_go", b_iter_go, 1);
        b_hd_valid = 1'b1;
        b_hd = 32'hDEAD_BEEF;
        tick();
        b_hd_valid = 1'b0;
        b_hd = 32'h0;
        check("b_k0_capture", b_chk_dec, 32'hDEAD_BEEF);
        tick();
        check("b_valid", b_out_valid, 1);
        check("b_iters", b_out_iters, 1);
        check("b_conv",  b_out_conv,  0);
        check("b_data",  b_out_data,  32'hDEAD_BEEF);
        check("b_no_second_go", b_iter_go, 0);
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        check("b_done_valid", b_out_valid, 0);
        check("b_done_busy",  b_busy,      0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
